// File: rtl/devolucion_cambio.sv
// devolucion_cambio: pays out change as greedy 5/2/1 coins, one coin per
// req/ack handshake with the ejector, with coin spacing and timeout measured
// in 1 s tick pulses.
// Ports: clock, reseteo (sync, active-low), tick, start, amount[AMT_W],
//   eject_ack -> eject_req, coin_sel[2], remaining[AMT_W], busy, done, fault.
module devolucion_cambio #(
  parameter int AMT_W         = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 3
) (
  input  logic             clock,
  input  logic             reseteo,
  input  logic             tick,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             eject_ack,
  output logic             eject_req,
  output logic [1:0]       coin_sel,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int MAXT =
    (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
  // One spare count so the GAP sum (count + this edge's tick) never wraps.
  localparam int CNT_W = $clog2(MAXT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           r_state, w_state;
  logic             r_req, w_req;
  logic [1:0]       r_sel, w_sel;
  logic [AMT_W-1:0] r_rem, w_rem;
  logic             r_done, w_done;
  logic             r_fault, w_fault;
  logic             r_busy, w_busy;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [AMT_W-1:0] w_val;
  logic [CNT_W-1:0] w_gap_sum;

  always_ff @(posedge clock) begin
    if (!reseteo) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_sel   <= 2'b00;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_sel   <= w_sel;
      r_rem   <= w_rem;
      r_done  <= w_done;
      r_fault <= w_fault;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_val = '0;
    unique case (r_sel)
      2'b11:   w_val = AMT_W'(5);
      2'b10:   w_val = AMT_W'(2);
      2'b01:   w_val = AMT_W'(1);
      default: w_val = '0;
    endcase
  end

  // Ticks seen in GAP including the one arriving on this edge.
  assign w_gap_sum = r_cnt + CNT_W'(tick);

  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_sel   = r_sel;
    w_rem   = r_rem;
    w_done  = 1'b0;
    w_fault = r_fault;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (amount != '0) begin
            w_rem   = amount;
            w_state = S_SELECT;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      S_SELECT: begin
        priority case (1'b1)
          (r_rem >= AMT_W'(5)): w_sel = 2'b11;
          (r_rem >= AMT_W'(2)): w_sel = 2'b10;
          default:              w_sel = 2'b01;
        endcase
        w_req   = 1'b1;
        w_cnt   = '0;
        w_state = S_REQ;
      end
      S_REQ: begin
        // Ack takes priority over a coincident timeout tick.
        if (eject_ack) begin
          w_rem   = r_rem - w_val;
          w_req   = 1'b0;
          w_sel   = 2'b00;
          w_cnt   = '0;
          w_state = S_GAP;
        end else if (tick) begin
          if (r_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
            w_req   = 1'b0;
            w_sel   = 2'b00;
            w_fault = 1'b1;
            w_state = S_FAULT;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick && (r_cnt < CNT_W'(GAP_TICKS)))
          w_cnt = r_cnt + CNT_W'(1);
        if ((w_gap_sum >= CNT_W'(GAP_TICKS)) && !eject_ack) begin
          if (r_rem == '0) begin
            w_done  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_state = S_SELECT;
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      S_FAULT: begin
        w_state = S_FAULT;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE) && (w_state != S_FAULT);
  end

  assign eject_req = r_req;
  assign coin_sel  = r_sel;
  assign remaining = r_rem;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_devolucion_cambio.sv
// tb_devolucion_cambio: randomized payouts against a greedy coin model,
// plus fixed reset, zero-amount, timeout, mid-reset and ignored-start cases.
module tb_devolucion_cambio;

  logic       clock = 1'b0;
  logic       reseteo;
  logic       tick;
  logic       start;
  logic [3:0] amount;
  logic       eject_ack;
  logic       eject_req;
  logic [1:0] coin_sel;
  logic [3:0] remaining;
  logic       busy;
  logic       done;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  int coins_q[$];
  int rems_q[$];
  int exp_c[$];
  int exp_r[$];
  int done_cnt;
  int rises;
  int unstable;
  bit faulted;

  devolucion_cambio dut (
    .clock     (clock),
    .reseteo   (reseteo),
    .tick      (tick),
    .start     (start),
    .amount    (amount),
    .eject_ack (eject_ack),
    .eject_req (eject_req),
    .coin_sel  (coin_sel),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  function automatic int coin_val(input logic [1:0] s);
    case (s)
      2'b11:   return 5;
      2'b10:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  // Greedy split from plain arithmetic: n/5 fives, then twos, then ones.
  task automatic model(input int n);
    int r;
    exp_c.delete();
    exp_r.delete();
    r = n;
    for (int i = 0; i < n / 5; i++) begin
      exp_c.push_back(5); exp_r.push_back(r); r -= 5;
    end
    for (int i = 0; i < (n % 5) / 2; i++) begin
      exp_c.push_back(2); exp_r.push_back(r); r -= 2;
    end
    if ((n % 5) % 2 == 1) begin
      exp_c.push_back(1); exp_r.push_back(r);
    end
  endtask

  task automatic kick(input int amt);
    @(negedge clock);
    start  = 1'b1;
    amount = 4'(amt);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reseteo = 1'b0;
    start = 1'b0; tick = 1'b0; eject_ack = 1'b0;
    @(negedge clock);
    reseteo = 1'b1;
  endtask

  // Acts as the ejector; race mode makes the ack land on the 3rd REQ tick.
  task automatic collect(input int dly, input bit race, input int mid_amt);
    int  c;
    bit  prev;
    bit  mid_done;
    int  post;
    int  last_sel;
    coins_q.delete();
    rems_q.delete();
    done_cnt = 0; rises = 0; unstable = 0; faulted = 0;
    c = 0; prev = 0; mid_done = 0; post = -1; last_sel = 0;
    for (int cyc = 0; cyc < 400 && post != 0 && !faulted; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) done_cnt++;
      if (fault) faulted = 1;
      if (eject_req && !prev) begin
        rises++;
        coins_q.push_back(coin_val(coin_sel));
        rems_q.push_back(int'(remaining));
        last_sel = int'(coin_sel);
        c = 0;
        if (mid_amt >= 0 && !mid_done) begin
          start = 1'b1; amount = 4'(mid_amt); mid_done = 1;
        end
      end else if (eject_req) begin
        c++;
        if (int'(coin_sel) != last_sel) unstable++;
      end
      prev = eject_req;
      if (!eject_req) eject_ack = 1'b0;
      else if (race ? (c == 4) : (c >= dly)) eject_ack = 1'b1;
      if (race && eject_req) tick = (c == 0 || c == 2 || c == 4);
      else tick = ($urandom_range(0, 3) == 0);
      if (done && post < 0) post = 3;
      else if (post > 0) post--;
    end
    tick = 1'b0;
    eject_ack = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (eject_req == lvl) ok = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (eject_req !== 1'b0 || coin_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_req got req=%b sel=%b exp 0 00", eject_req, coin_sel);
    end
    n_tests++;
    if (remaining !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rem got rem=%0d busy=%b exp 0 0", remaining, busy);
    end
    n_tests++;
    if (done !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got done=%b fault=%b exp 0 0", done, fault);
    end
  endtask

  task automatic test_fixed();
    int amts[3] = '{9, 8, 15};
    foreach (amts[k]) begin
      model(amts[k]);
      kick(amts[k]);
      collect(2, 1'b0, -1);
      n_tests++;
      if (coins_q.size() != exp_c.size()) begin
        n_fail++;
        $display("FAIL fixed_len amt=%0d got %0d coins exp %0d",
                 amts[k], coins_q.size(), exp_c.size());
      end else begin
        foreach (exp_c[i]) begin
          n_tests++;
          if (coins_q[i] !== exp_c[i] || rems_q[i] !== exp_r[i]) begin
            n_fail++;
            $display("FAIL fixed_coin amt=%0d #%0d got %0d/%0d exp %0d/%0d",
                     amts[k], i, coins_q[i], rems_q[i], exp_c[i], exp_r[i]);
          end
        end
      end
      n_tests++;
      if (rises != 3 || done_cnt != 1 || unstable != 0) begin
        n_fail++;
        $display("FAIL fixed_hs amt=%0d got rises=%0d done=%0d unst=%0d exp 3 1 0",
                 amts[k], rises, done_cnt, unstable);
      end
      n_tests++;
      if (busy !== 1'b0 || remaining !== 4'd0 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_end amt=%0d got busy=%b rem=%0d fault=%b exp 0 0 0",
                 amts[k], busy, remaining, fault);
      end
    end
  endtask

  task automatic test_zero();
    kick(0);
    @(negedge clock);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || eject_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got done=%b busy=%b req=%b exp 1 0 0",
               done, busy, eject_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || eject_req !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_after cyc=%0d got done=%b busy=%b req=%b exp 0 0 0",
                 i, done, busy, eject_req);
      end
    end
  endtask

  task automatic test_random();
    int amt;
    for (int k = 0; k < 20; k++) begin
      amt = $urandom_range(0, 15);
      model(amt);
      kick(amt);
      collect($urandom_range(0, 2), 1'b0, -1);
      n_tests++;
      if (coins_q.size() != exp_c.size() || done_cnt != 1 || faulted) begin
        n_fail++;
        $display("FAIL rand_run amt=%0d got coins=%0d done=%0d fault=%0d exp %0d 1 0",
                 amt, coins_q.size(), done_cnt, faulted, exp_c.size());
      end else begin
        foreach (exp_c[i]) begin
          n_tests++;
          if (coins_q[i] !== exp_c[i] || rems_q[i] !== exp_r[i]) begin
            n_fail++;
            $display("FAIL rand_coin amt=%0d #%0d got %0d/%0d exp %0d/%0d",
                     amt, i, coins_q[i], rems_q[i], exp_c[i], exp_r[i]);
          end
        end
      end
      n_tests++;
      if (busy !== 1'b0 || remaining !== 4'd0) begin
        n_fail++;
        $display("FAIL rand_end amt=%0d got busy=%b rem=%0d exp 0 0",
                 amt, busy, remaining);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    tick = 1'b0;
    eject_ack = 1'b0;
    kick(6);
    wait_req(1'b1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_req got req=%b exp 1 within budget", eject_req);
    end
    repeat (2) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
    end
    n_tests++;
    if (fault !== 1'b0 || eject_req !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early got fault=%b req=%b exp 0 1", fault, eject_req);
    end
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    n_tests++;
    if (fault !== 1'b1 || eject_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fault got fault=%b req=%b busy=%b exp 1 0 0",
               fault, eject_req, busy);
    end
    start = 1'b1;
    amount = 4'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (fault !== 1'b1 || eject_req !== 1'b0 || busy !== 1'b0 || remaining !== 4'd6) begin
      n_fail++;
      $display("FAIL to_hold got fault=%b req=%b busy=%b rem=%0d exp 1 0 0 6",
               fault, eject_req, busy, remaining);
    end
    do_reset();
    n_tests++;
    if (fault !== 1'b0 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL to_clear got fault=%b rem=%0d exp 0 0", fault, remaining);
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, ok3;
    tick = 1'b1;
    kick(9);
    wait_req(1'b1, ok1);
    eject_ack = 1'b1;
    wait_req(1'b0, ok2);
    eject_ack = 1'b0;
    wait_req(1'b1, ok3);
    n_tests++;
    if (!(ok1 && ok2 && ok3) || remaining !== 4'd4) begin
      n_fail++;
      $display("FAIL rmid_second got ok=%0d rem=%0d exp 1 4",
               ok1 && ok2 && ok3, remaining);
    end
    reseteo = 1'b0;
    tick = 1'b0;
    @(negedge clock);
    reseteo = 1'b1;
    n_tests++;
    if (eject_req !== 1'b0 || remaining !== 4'd0 || busy !== 1'b0 || coin_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_reset got req=%b rem=%0d busy=%b sel=%b exp 0 0 0 00",
               eject_req, remaining, busy, coin_sel);
    end
    model(7);
    kick(7);
    collect(1, 1'b0, -1);
    n_tests++;
    if (coins_q != exp_c || rems_q != exp_r || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rmid_fresh got coins=%p rems=%p done=%0d exp %p %p 1",
               coins_q, rems_q, done_cnt, exp_c, exp_r);
    end
  endtask

  task automatic test_mid_start();
    model(7);
    kick(7);
    collect(0, 1'b1, 3);
    n_tests++;
    if (coins_q != exp_c || rems_q != exp_r) begin
      n_fail++;
      $display("FAIL mstart_coins got %p/%p exp %p/%p",
               coins_q, rems_q, exp_c, exp_r);
    end
    n_tests++;
    if (faulted || fault !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL mstart_race got fault=%0d/%b done=%0d exp 0/0 1",
               faulted, fault, done_cnt);
    end
    n_tests++;
    if (busy !== 1'b0 || eject_req !== 1'b0 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL mstart_idle got busy=%b req=%b rem=%0d exp 0 0 0",
               busy, eject_req, remaining);
    end
  endtask

  initial begin
    reseteo = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    amount = 4'd0;
    eject_ack = 1'b0;
    test_reset();
    test_fixed();
    test_zero();
    test_random();
    test_timeout();
    test_reset_mid();
    test_mid_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
